// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store, routing in-order
// responses back to their issuer through a small ID FIFO.
module mem_req_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        sram_req,
   output logic        sram_wr,
   output logic [1:0]  sram_size,
   output logic [31:0] sram_addr,
   output logic [3:0]  sram_wstrb,
   output logic [31:0] sram_wdata,
   input  logic        sram_addr_ok,
   input  logic        sram_data_ok,
   input  logic [31:0] sram_rdata
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {StIdle, StGntD, StGntI} state_e;

   state_e                     state_q;
   logic [CntW-1:0]            count_q;
   logic [PtrW-1:0]            rd_ptr_q;
   logic [PtrW-1:0]            wr_ptr_q;
   logic [MAX_OUTSTANDING-1:0] id_q;     // 1 = data requester, 0 = fetch

   logic can_grant;
   logic push;
   logic pop;
   logic head_id;

   // Grant decision looks only at the registered count, so a same-cycle pop
   // does not open a slot until the following cycle.
   assign can_grant = (count_q < MaxCnt);
   assign push      = (state_q != StIdle) & sram_addr_ok;
   assign pop       = sram_data_ok & (count_q != '0);
   assign head_id   = id_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         id_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (can_grant && data_req) begin
                  state_q <= StGntD;
               end else if (can_grant && inst_req) begin
                  state_q <= StGntI;
               end
            end
            StGntD, StGntI: begin
               if (sram_addr_ok) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (push) begin
            id_q[wr_ptr_q] <= (state_q == StGntD);
            wr_ptr_q       <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   always_comb begin
      sram_req     = 1'b0;
      sram_wr      = 1'b0;
      sram_size    = 2'd0;
      sram_addr    = 32'h0;
      sram_wstrb   = 4'h0;
      sram_wdata   = 32'h0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      unique case (state_q)
         StGntD: begin
            sram_req     = 1'b1;
            sram_wr      = data_wr;
            sram_size    = data_size;
            sram_addr    = data_addr;
            sram_wstrb   = data_wstrb;
            sram_wdata   = data_wdata;
            data_addr_ok = sram_addr_ok;
         end
         StGntI: begin
            sram_req     = 1'b1;
            sram_size    = 2'd2;
            sram_addr    = inst_addr;
            inst_addr_ok = sram_addr_ok;
         end
         default: ;
      endcase
   end

   assign inst_data_ok = pop & ~head_id;
   assign data_data_ok = pop & head_id;
   assign inst_rdata   = sram_rdata;
   assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a per-cycle vector table followed by
// hand-written reset-during-accept and bounded grant-latency sequences.
module tb_mem_req_arbiter;

   localparam logic [1:0] GN = 2'd0;  // no grant visible
   localparam logic [1:0] GI = 2'd1;  // fetch granted
   localparam logic [1:0] GD = 2'd2;  // load/store granted

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_req;
   logic        sram_wr;
   logic [1:0]  sram_size;
   logic [31:0] sram_addr;
   logic [3:0]  sram_wstrb;
   logic [31:0] sram_wdata;
   logic        sram_addr_ok;
   logic        sram_data_ok;
   logic [31:0] sram_rdata;

   always #5 clk = ~clk;

   mem_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .sram_req     (sram_req),
      .sram_wr      (sram_wr),
      .sram_size    (sram_size),
      .sram_addr    (sram_addr),
      .sram_wstrb   (sram_wstrb),
      .sram_wdata   (sram_wdata),
      .sram_addr_ok (sram_addr_ok),
      .sram_data_ok (sram_data_ok),
      .sram_rdata   (sram_rdata)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      int          dkind;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic [1:0]  gnt;   // expected grant visible on the sram port this cycle
      logic [3:0]  oks;   // expected {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input string n, input int r, input int ireq, input logic [31:0] ia,
                      input int dk, input int aok, input int dok, input logic [31:0] rd,
                      input logic [1:0] g, input int oks);
      vec_t v;
      v.name  = n;
      v.rst   = (r != 0);
      v.ireq  = (ireq != 0);
      v.iaddr = ia;
      v.dkind = dk;
      v.aok   = (aok != 0);
      v.dok   = (dok != 0);
      v.rdata = rd;
      v.gnt   = g;
      v.oks   = 4'(oks);
      vecs.push_back(v);
   endtask

   // Data-side request patterns: 0 idle, 1 word store, 2/3 word loads, 4 half store, 5 load.
   task automatic drive_data(input int kind);
      data_req   = (kind != 0);
      data_wr    = 1'b0;
      data_size  = 2'd2;
      data_addr  = 32'h0;
      data_wstrb = 4'h0;
      data_wdata = 32'h0;
      case (kind)
         1: begin
            data_wr = 1'b1; data_addr = 32'h100; data_wstrb = 4'hf; data_wdata = 32'hdeadbeef;
         end
         2: data_addr = 32'h200;
         3: data_addr = 32'h204;
         4: begin
            data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h300;
            data_wstrb = 4'h3; data_wdata = 32'h12345678;
         end
         5: data_addr = 32'h400;
         default: data_size = 2'd0;
      endcase
   endtask

   function automatic logic [79:0] act_bundle();
      return {4'h0, sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
              inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
   endfunction

   function automatic logic [79:0] exp_bundle(input logic [1:0] g, input logic [3:0] oks);
      logic [71:0] s;
      case (g)
         GI:      s = {1'b1, 1'b0, 2'd2, inst_addr, 4'h0, 32'h0};
         GD:      s = {1'b1, data_wr, data_size, data_addr, data_wstrb, data_wdata};
         default: s = '0;
      endcase
      return {4'h0, s, oks};
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int n;

      //   name               rst ireq iaddr          dk aok dok rdata          gnt oks
      add("fetch_idle",        0, 1, 32'h1c000000, 0, 0, 0, 32'h0,        GN, 'b0000);
      add("fetch_grant",       0, 1, 32'h1c000000, 0, 1, 0, 32'h0,        GI, 'b1000);
      add("fetch_wait",        0, 0, 32'h0,        0, 0, 0, 32'h0,        GN, 'b0000);
      add("fetch_resp",        0, 0, 32'h0,        0, 0, 1, 32'h02800000, GN, 'b0010);
      add("stray_ok_empty",    0, 0, 32'h0,        0, 0, 1, 32'h0badf00d, GN, 'b0000);
      add("prio_idle",         0, 1, 32'h1c000004, 1, 0, 0, 32'h0,        GN, 'b0000);
      add("prio_store_wait",   0, 1, 32'h1c000004, 1, 0, 0, 32'h0,        GD, 'b0000);
      add("prio_store_acc",    0, 1, 32'h1c000004, 1, 1, 0, 32'h0,        GD, 'b0100);
      add("prio_fetch_idle",   0, 1, 32'h1c000004, 0, 0, 0, 32'h0,        GN, 'b0000);
      add("prio_fetch_acc",    0, 1, 32'h1c000004, 0, 1, 0, 32'h0,        GI, 'b1000);
      add("prio_resp_data",    0, 0, 32'h0,        0, 0, 1, 32'h0,        GN, 'b0001);
      add("prio_resp_inst",    0, 0, 32'h0,        0, 0, 1, 32'h11223344, GN, 'b0010);
      add("full_ld0_idle",     0, 0, 32'h0,        2, 0, 0, 32'h0,        GN, 'b0000);
      add("full_ld0_acc",      0, 0, 32'h0,        2, 1, 0, 32'h0,        GD, 'b0100);
      add("full_ld1_idle",     0, 0, 32'h0,        3, 0, 0, 32'h0,        GN, 'b0000);
      add("full_ld1_acc",      0, 0, 32'h0,        3, 1, 0, 32'h0,        GD, 'b0100);
      add("full_block0",       0, 1, 32'h1c000008, 0, 0, 0, 32'h0,        GN, 'b0000);
      add("full_block1",       0, 1, 32'h1c000008, 0, 0, 0, 32'h0,        GN, 'b0000);
      add("full_pop",          0, 1, 32'h1c000008, 0, 0, 1, 32'haaaa0000, GN, 'b0001);
      add("full_unblock",      0, 1, 32'h1c000008, 0, 0, 0, 32'h0,        GN, 'b0000);
      add("full_fetch_gnt",    0, 1, 32'h1c000008, 0, 0, 0, 32'h0,        GI, 'b0000);
      add("push_pop",          0, 1, 32'h1c000008, 0, 1, 1, 32'hbbbb0000, GI, 'b1001);
      add("push_pop_head",     0, 0, 32'h0,        0, 0, 1, 32'hcccc0000, GN, 'b0010);
      add("stray_ok_empty2",   0, 0, 32'h0,        0, 0, 1, 32'h0,        GN, 'b0000);
      add("stall_idle",        0, 1, 32'h1c00000c, 4, 0, 0, 32'h0,        GN, 'b0000);
      for (int i = 0; i < 5; i++) begin
         add($sformatf("stall_%0d", i), 0, 1, 32'h1c00000c, 4, 0, 0, 32'h0, GD, 'b0000);
      end
      add("stall_acc",         0, 1, 32'h1c00000c, 4, 1, 0, 32'h0,        GD, 'b0100);
      add("stall_fetch_idle",  0, 1, 32'h1c00000c, 0, 0, 0, 32'h0,        GN, 'b0000);
      add("stall_fetch_acc",   0, 1, 32'h1c00000c, 0, 1, 0, 32'h0,        GI, 'b1000);
      add("reset_full",        1, 0, 32'h0,        0, 0, 0, 32'h0,        GN, 'b0000);
      add("post_rst_stray0",   0, 0, 32'h0,        0, 0, 1, 32'hdddd0000, GN, 'b0000);
      add("post_rst_stray1",   0, 0, 32'h0,        0, 0, 1, 32'heeee0000, GN, 'b0000);

      reset        = 1'b1;
      inst_req     = 1'b0;
      inst_addr    = 32'h0;
      sram_addr_ok = 1'b0;
      sram_data_ok = 1'b0;
      sram_rdata   = 32'h0;
      drive_data(0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state", act_bundle(), exp_bundle(GN, 4'b0000));
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         reset        = vecs[i].rst;
         inst_req     = vecs[i].ireq;
         inst_addr    = vecs[i].iaddr;
         sram_addr_ok = vecs[i].aok;
         sram_data_ok = vecs[i].dok;
         sram_rdata   = vecs[i].rdata;
         drive_data(vecs[i].dkind);
         @(negedge clk);
         check(vecs[i].name, act_bundle(), exp_bundle(vecs[i].gnt, vecs[i].oks));
         if (vecs[i].oks[1]) check({vecs[i].name, "_irdata"}, 80'(inst_rdata), 80'(vecs[i].rdata));
         if (vecs[i].oks[0]) check({vecs[i].name, "_drdata"}, 80'(data_rdata), 80'(vecs[i].rdata));
         @(posedge clk);
         #1;
      end

      // Reset asserted in the very cycle the memory accepts: the push must be discarded.
      reset        = 1'b0;
      inst_req     = 1'b0;
      sram_addr_ok = 1'b0;
      sram_data_ok = 1'b0;
      drive_data(5);
      @(negedge clk);
      check("rst_acc_idle", act_bundle(), exp_bundle(GN, 4'b0000));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_acc_granted", act_bundle(), exp_bundle(GD, 4'b0000));
      sram_addr_ok = 1'b1;
      reset        = 1'b1;
      #1;
      check("rst_acc_addr_ok", act_bundle(), exp_bundle(GD, 4'b0100));
      @(posedge clk);
      #1;
      reset        = 1'b0;
      sram_addr_ok = 1'b0;
      drive_data(0);
      sram_data_ok = 1'b1;
      sram_rdata   = 32'h77770000;
      @(negedge clk);
      check("rst_acc_dropped", act_bundle(), exp_bundle(GN, 4'b0000));
      @(posedge clk);
      #1;
      sram_data_ok = 1'b0;

      // Lone fetch with a bounded wait for the grant.
      inst_req  = 1'b1;
      inst_addr = 32'h1c000010;
      n = 0;
      @(negedge clk);
      while (sram_req !== 1'b1 && n < 4) begin
         @(posedge clk);
         #1;
         n++;
         @(negedge clk);
      end
      check("grant_latency", 80'(n), 80'(1));
      sram_addr_ok = 1'b1;
      #1;
      check("late_fetch_acc", act_bundle(), exp_bundle(GI, 4'b1000));
      @(posedge clk);
      #1;
      inst_req     = 1'b0;
      sram_addr_ok = 1'b0;
      @(posedge clk);
      #1;
      sram_data_ok = 1'b1;
      sram_rdata   = 32'h5a5a5a5a;
      @(negedge clk);
      check("late_fetch_resp", 80'({inst_data_ok, data_data_ok}), 80'(2'b10));
      check("late_fetch_rdata", 80'(inst_rdata), 80'(32'h5a5a5a5a));
      @(posedge clk);
      #1;
      sram_data_ok = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
